peltier_regulator: RTL and testbench
====================================

PELTIER_REGULATOR -- requirements
Module: peltier_regulator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 SAMPLE_PERIOD, default 1000000: cycles between sample triggers (10 ms at 100 MHz).
REQ-003 TIMEOUT, default 65535: maximum cycles to wait for ADC data.
REQ-004 The ports SHALL be, in order:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- enable  in  1  regulation active
- setpoint  in  10  target ADC code
- bias  in  8  feed-forward duty
- kp  in  8  proportional gain, unsigned, scaled by 1/16
- ki_shift  in  4  integral attenuation, arithmetic right shift
- mcp_busy  in  1  MCP3008 interface busy
- mcp_data  in  16  ADC word; only [9:0] is used
- mcp_avail  in  1  ADC data available
- mcp_accept  out  1  ADC data consumed
- sample  out  1  MCP3008 sample trigger (rising-edge sensitive)
- duty  out  8  Peltier PWM duty cycle
- last_code  out  10  last captured ADC code
- fault  out  1  sticky timeout flag

Function
REQ-005 The state machine SHALL have the states IDLE, WAIT, TRIG1, TRIG2, WAIT_DATA, CALC and APPLY.
REQ-006 IDLE SHALL hold duty=0 and acc=0, and SHALL go to WAIT with the period counter at 0 when enable=1.
REQ-007 WAIT SHALL increment the period counter and go to TRIG1 when the counter reaches SAMPLE_PERIOD-1 and mcp_busy=0.
REQ-008 If mcp_busy=1 at period expiry, WAIT SHALL hold the counter saturated and trigger on the first cycle mcp_busy=0.
REQ-009 sample SHALL be 1 in TRIG1 and TRIG2 only (exactly 2 cycles); TRIG2 SHALL go to WAIT_DATA with the timeout counter cleared.
REQ-010 In WAIT_DATA, mcp_accept SHALL equal mcp_avail (combinational).
REQ-011 In the cycle mcp_avail=1, the block SHALL capture mcp_data[9:0] into last_code and go to CALC.
REQ-012 mcp_accept SHALL be 0 in all states other than WAIT_DATA.
REQ-013 If WAIT_DATA reaches TIMEOUT cycles without mcp_avail, the block SHALL set fault=1, duty=0 and acc=0, and return to WAIT with the counter at 0.
REQ-014 CALC SHALL register err = code - setpoint as 11-bit signed, and p = (err*kp)>>>4 as 15-bit signed.
REQ-015 APPLY SHALL compute u = bias + p + (acc>>>ki_shift) in 18-bit signed.
REQ-016 APPLY SHALL load duty with u clamped to 0..255, then return to WAIT with the counter at 0.
REQ-017 acc SHALL be a 16-bit signed accumulator updated in APPLY as acc+err, saturating at -32768/32767.
REQ-018 Anti-windup: acc SHALL NOT update when u>255 and err>0, or when u<0 and err<0.
REQ-019 A successful APPLY SHALL NOT clear fault.
REQ-020 When enable falls in any state, the next state SHALL be IDLE: sample=0, duty=0, acc=0, fault=0; any pending mcp_avail SHALL NOT be accepted.
REQ-021 The total latency from capture to duty update SHALL be 2 cycles.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, duty=0, last_code=0, acc=0, fault=0, sample=0, mcp_accept=0, all counters 0.
REQ-023 rst SHALL take priority over enable and over all in-flight operations.

Structure
REQ-024 State encodings and default parameter values SHALL live in the shared header peltier_regulator.vh.
REQ-025 The arithmetic of REQ-014 to REQ-018 SHALL be placed in the sub-module peltier_pi_calc.
REQ-026 One peltier_regulator instance SHALL exist per Peltier channel, with duty driving the PWM comparator in place of the register value.

Verification
REQ-027 setpoint=512, code=512, bias=100, kp=16, ki_shift=15 -> duty=100 two cycles after accept; acc=0.
REQ-028 setpoint=512, code=600, bias=100, kp=16, ki_shift=15 -> err=88, p=88, duty=188, acc=88.
REQ-029 setpoint=0, code=1023, bias=200, kp=255 -> duty=255 and acc unchanged (anti-windup); with code=0, setpoint=1023, bias=0 -> duty=0.
REQ-030 SAMPLE_PERIOD=16, TIMEOUT=8, mcp_avail held 0 -> sample pulses for 2 cycles, fault=1 after 8 cycles, duty=0, next trigger 16 cycles later.
REQ-031 mcp_busy=1 at period expiry for 5 cycles -> sample rises on the cycle after mcp_busy falls, never earlier.
REQ-032 enable dropped during WAIT_DATA with mcp_avail=1 in the same cycle -> mcp_accept=0, IDLE next cycle, duty=0; rst mid-APPLY -> all outputs 0.

Source files
------------

// File: rtl/peltier_regulator_pkg.sv
// Shared types, default parameters and saturation helpers for the Peltier regulator.
package peltier_regulator_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StTrig1,
    StTrig2,
    StWaitData,
    StCalc,
    StApply
  } state_e;

  localparam int unsigned SamplePeriodDefault = 1000000;
  localparam int unsigned TimeoutDefault      = 65535;

  function automatic logic [7:0] clamp_duty(input logic signed [17:0] u);
    if (u < 18'sd0) begin
      return 8'd0;
    end else if (u > 18'sd255) begin
      return 8'd255;
    end else begin
      return u[7:0];
    end
  endfunction

  function automatic logic signed [15:0] sat_acc(input logic signed [16:0] s);
    if (s > 17'sd32767) begin
      return 16'sh7fff;
    end else if (s < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return s[15:0];
    end
  endfunction

endpackage

// File: rtl/peltier_pi_calc.sv
// Combinational PI arithmetic: error/proportional terms and the clamped duty / accumulator update.
module peltier_pi_calc
  import peltier_regulator_pkg::*;
(
  input  logic        [9:0]  code,
  input  logic        [9:0]  setpoint,
  input  logic        [7:0]  kp,
  input  logic        [7:0]  bias,
  input  logic        [3:0]  ki_shift,
  input  logic signed [10:0] cur_err,
  input  logic signed [14:0] cur_p,
  input  logic signed [15:0] acc,
  output logic signed [10:0] err,
  output logic signed [14:0] p,
  output logic        [7:0]  duty_next,
  output logic signed [15:0] acc_next
);

  logic signed [19:0] prod;
  logic signed [15:0] acc_sh;
  logic signed [17:0] u;
  logic signed [16:0] acc_sum;
  logic               windup;

  always_comb begin
    err       = $signed({1'b0, code}) - $signed({1'b0, setpoint});
    prod      = 20'(err) * $signed({12'b0, kp});
    p         = 15'(prod >>> 4);
    acc_sh    = acc >>> ki_shift;
    u         = $signed({10'b0, bias}) + 18'(cur_p) + 18'(acc_sh);
    duty_next = clamp_duty(u);
    acc_sum   = 17'(acc) + 17'(cur_err);
    // Freeze the integrator while the output is pinned and the error pushes further out.
    windup    = ((u > 18'sd255) && (cur_err > 11'sd0)) || ((u < 18'sd0) && (cur_err < 11'sd0));
    acc_next  = windup ? acc : sat_acc(acc_sum);
  end

endmodule

// File: rtl/peltier_regulator.sv
// Periodic MCP3008 sampling and PI regulation of a single Peltier channel's PWM duty.
module peltier_regulator
  import peltier_regulator_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = SamplePeriodDefault,
  parameter int unsigned TIMEOUT       = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [9:0]  setpoint,
  input  logic [7:0]  bias,
  input  logic [7:0]  kp,
  input  logic [3:0]  ki_shift,
  input  logic        mcp_busy,
  input  logic [15:0] mcp_data,
  input  logic        mcp_avail,
  output logic        mcp_accept,
  output logic        sample,
  output logic [7:0]  duty,
  output logic [9:0]  last_code,
  output logic        fault
);

  localparam int unsigned PerW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PerW-1:0] PerLast = PerW'(SAMPLE_PERIOD - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);

  state_e             state_q;
  logic [PerW-1:0]    per_cnt_q;
  logic [ToW-1:0]     to_cnt_q;
  logic signed [15:0] acc_q;
  logic signed [10:0] err_q;
  logic signed [14:0] p_q;
  logic signed [10:0] err_c;
  logic signed [14:0] p_c;
  logic [7:0]         duty_c;
  logic signed [15:0] acc_c;
  logic               unused_data;

  assign unused_data = ^mcp_data[15:10];

  // Accept is suppressed when enable falls so a pending word stays with the ADC interface.
  assign mcp_accept = (state_q == StWaitData) && mcp_avail && enable && !rst;

  peltier_pi_calc u_calc (
    .code      (last_code),
    .setpoint  (setpoint),
    .kp        (kp),
    .bias      (bias),
    .ki_shift  (ki_shift),
    .cur_err   (err_q),
    .cur_p     (p_q),
    .acc       (acc_q),
    .err       (err_c),
    .p         (p_c),
    .duty_next (duty_c),
    .acc_next  (acc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      per_cnt_q <= '0;
      to_cnt_q  <= '0;
      acc_q     <= '0;
      err_q     <= '0;
      p_q       <= '0;
      sample    <= 1'b0;
      duty      <= '0;
      last_code <= '0;
      fault     <= 1'b0;
    end else if (!enable) begin
      state_q   <= StIdle;
      per_cnt_q <= '0;
      to_cnt_q  <= '0;
      acc_q     <= '0;
      sample    <= 1'b0;
      duty      <= '0;
      fault     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          duty      <= '0;
          acc_q     <= '0;
          per_cnt_q <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          // Counter saturates at the period end until the ADC interface is free.
          if (per_cnt_q == PerLast) begin
            if (!mcp_busy) begin
              sample  <= 1'b1;
              state_q <= StTrig1;
            end
          end else begin
            per_cnt_q <= per_cnt_q + 1'b1;
          end
        end
        StTrig1: state_q <= StTrig2;
        StTrig2: begin
          sample   <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= StWaitData;
        end
        StWaitData: begin
          if (mcp_avail) begin
            last_code <= mcp_data[9:0];
            state_q   <= StCalc;
          end else if (to_cnt_q == ToLast) begin
            fault     <= 1'b1;
            duty      <= '0;
            acc_q     <= '0;
            per_cnt_q <= '0;
            state_q   <= StWait;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StCalc: begin
          err_q   <= err_c;
          p_q     <= p_c;
          state_q <= StApply;
        end
        StApply: begin
          duty      <= duty_c;
          acc_q     <= acc_c;
          per_cnt_q <= '0;
          state_q   <= StWait;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_peltier_regulator.sv
// Directed bench for peltier_regulator with a short sample period and timeout.
module tb_peltier_regulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  setpoint;
  logic [7:0]  bias;
  logic [7:0]  kp;
  logic [3:0]  ki_shift;
  logic        mcp_busy;
  logic [15:0] mcp_data;
  logic        mcp_avail;
  logic        mcp_accept;
  logic        sample;
  logic [7:0]  duty;
  logic [9:0]  last_code;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  peltier_regulator #(
    .SAMPLE_PERIOD (16),
    .TIMEOUT       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .setpoint   (setpoint),
    .bias       (bias),
    .kp         (kp),
    .ki_shift   (ki_shift),
    .mcp_busy   (mcp_busy),
    .mcp_data   (mcp_data),
    .mcp_avail  (mcp_avail),
    .mcp_accept (mcp_accept),
    .sample     (sample),
    .duty       (duty),
    .last_code  (last_code),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_trig(input string tag);
    int i;
    i = 0;
    while (sample !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    check({tag, "_trig"}, 32'(sample), 32'd1);
  endtask

  // Starts in TRIG1; ends at the negedge after the APPLY edge.
  task automatic run_pi(input string tag, input logic [9:0] code, input logic [7:0] exp_duty,
                        input logic [7:0] prev_duty);
    wait_trig(tag);
    tick();
    check({tag, "_trig2"}, 32'(sample), 32'd1);
    tick();
    check({tag, "_trig_end"}, 32'(sample), 32'd0);
    mcp_data  = {6'b101101, code};
    mcp_avail = 1'b1;
    #1;
    check({tag, "_accept"}, 32'(mcp_accept), 32'd1);
    tick();
    mcp_avail = 1'b0;
    check({tag, "_code"}, 32'(last_code), 32'(code));
    tick();
    check({tag, "_duty_hold"}, 32'(duty), 32'(prev_duty));
    tick();
    check({tag, "_duty"}, 32'(duty), 32'(exp_duty));
  endtask

  initial begin
    int early;
    rst = 1'b1; enable = 1'b0; setpoint = 10'd512; bias = 8'd100; kp = 8'd16;
    ki_shift = 4'd15; mcp_busy = 1'b0; mcp_data = '0; mcp_avail = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_code", 32'(last_code), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_accept", 32'(mcp_accept), 32'd0);

    // First trigger: one cycle to leave IDLE plus 16 period cycles.
    enable = 1'b1;
    repeat (16) tick();
    check("period_early", 32'(sample), 32'd0);
    tick();
    check("period_edge", 32'(sample), 32'd1);
    run_pi("t_zero_err", 10'd512, 8'd100, 8'd0);

    run_pi("t_err88", 10'd600, 8'd188, 8'd100);

    setpoint = 10'd0; bias = 8'd200; kp = 8'd255;
    run_pi("t_sat_hi", 10'd1023, 8'd255, 8'd188);

    // With err=0, kp=0, bias=0, ki_shift=0 the duty equals acc.
    setpoint = 10'd300; bias = 8'd0; kp = 8'd0; ki_shift = 4'd0;
    run_pi("t_acc_hold1", 10'd300, 8'd88, 8'd255);

    setpoint = 10'd1023; bias = 8'd0; kp = 8'd255; ki_shift = 4'd15;
    run_pi("t_sat_lo", 10'd0, 8'd0, 8'd88);

    setpoint = 10'd300; bias = 8'd0; kp = 8'd0; ki_shift = 4'd0;
    run_pi("t_acc_hold2", 10'd300, 8'd88, 8'd0);

    // Timeout with no data.
    wait_trig("t_to");
    tick();
    check("to_trig2", 32'(sample), 32'd1);
    tick();
    check("to_trig_end", 32'(sample), 32'd0);
    repeat (7) tick();
    check("to_fault_early", 32'(fault), 32'd0);
    tick();
    check("to_fault", 32'(fault), 32'd1);
    check("to_duty", 32'(duty), 32'd0);
    repeat (15) tick();
    check("to_next_early", 32'(sample), 32'd0);
    tick();
    check("to_next_trig", 32'(sample), 32'd1);

    // acc cleared by the timeout: bias alone sets the duty; fault stays set.
    bias = 8'd50;
    run_pi("t_acc_clr", 10'd300, 8'd50, 8'd0);
    check("fault_sticky", 32'(fault), 32'd1);

    // Busy at period expiry for 5 cycles.
    mcp_busy = 1'b1;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample !== 1'b0) early++;
    end
    check("busy_no_trig", 32'(early), 32'd0);
    mcp_busy = 1'b0;
    tick();
    check("busy_trig", 32'(sample), 32'd1);

    // Enable dropped in WAIT_DATA while data is offered.
    tick();
    tick();
    mcp_data  = 16'd777;
    mcp_avail = 1'b1;
    enable    = 1'b0;
    #1;
    check("dis_accept", 32'(mcp_accept), 32'd0);
    tick();
    mcp_avail = 1'b0;
    check("dis_duty", 32'(duty), 32'd0);
    check("dis_fault", 32'(fault), 32'd0);
    check("dis_sample", 32'(sample), 32'd0);
    check("dis_code", 32'(last_code), 32'd300);

    // Reset while in APPLY.
    enable = 1'b1; setpoint = 10'd512; bias = 8'd100; kp = 8'd16; ki_shift = 4'd15;
    wait_trig("t_rst_to");
    tick();
    tick();
    repeat (8) tick();
    check("rst_pre_fault", 32'(fault), 32'd1);
    wait_trig("t_rst");
    tick();
    tick();
    mcp_data  = 16'd600;
    mcp_avail = 1'b1;
    tick();
    mcp_avail = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_apply_duty", 32'(duty), 32'd0);
    check("rst_apply_code", 32'(last_code), 32'd0);
    check("rst_apply_fault", 32'(fault), 32'd0);
    check("rst_apply_sample", 32'(sample), 32'd0);
    check("rst_apply_accept", 32'(mcp_accept), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
